hs_unit_reset_seq: RTL

HS_UNIT_RESET_SEQ -- requirements
Module: hs_unit_reset_seq

---
 rtl/hs_rst_pkg.sv | 7 +
 rtl/hs_unit_rst_sync_chain.sv | 15 +
 rtl/hs_unit_reset_seq.sv | 83 ++++++++
 3 files changed

// File: rtl/hs_rst_pkg.sv
// hs_rst_pkg: shared FSM state type and counter sizing helper for the reset sequencer
package hs_rst_pkg;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/hs_unit_rst_sync_chain.sv
// hs_unit_rst_sync_chain: async-assert, sync-release reset synchroniser
module hs_unit_rst_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic aresetn,
  output logic sync_n
);
  logic [STAGES-1:0] ff;
  // shift ones in after release; any aresetn assertion clears the whole chain at once
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) ff <= '0;
    else ff <= {ff[STAGES-2:0], 1'b1};
  assign sync_n = ff[STAGES-1];
endmodule

// File: rtl/hs_unit_reset_seq.sv
// hs_unit_reset_seq: stretched, staggered release of NUM_OUT active-low resets
module hs_unit_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_OUT        = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int RELEASE_GAP    = 4
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_outn,
  output logic               all_released,
  output logic               busy
);
  import hs_rst_pkg::*;
  localparam int CW = cnt_width(STRETCH_CYCLES, RELEASE_GAP);
  localparam logic [CW-1:0] ST_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(RELEASE_GAP - 1);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $fatal(1, "SYNC_STAGES out of range 2..4");
  end
  if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num
    $fatal(1, "NUM_OUT out of range 1..8");
  end
  if (STRETCH_CYCLES < 1) begin : g_bad_stretch
    $fatal(1, "STRETCH_CYCLES must be >= 1");
  end
  if (RELEASE_GAP < 1) begin : g_bad_gap
    $fatal(1, "RELEASE_GAP must be >= 1");
  end
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              sync_n;
  logic [NUM_OUT-1:0] nxt;
  logic              nxt_all;
  hs_unit_rst_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .aresetn (aresetn),
    .sync_n  (sync_n)
  );
  // outputs form a thermometer code, so releasing the next index is a shift-in of one
  always_comb begin
    nxt     = NUM_OUT'({rst_outn, 1'b1});
    nxt_all = &nxt;
  end
  // sequencer: stretch in HOLD, stagger releases in RELEASE, idle in RUN
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      state        <= HOLD;
      cnt          <= '0;
      rst_outn     <= '0;
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else if (sw_rst_req) begin
      state        <= HOLD;
      cnt          <= '0;
      rst_outn     <= '0;
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else begin
      case (state)
        HOLD:
          if (!sync_n) cnt <= '0;
          else if (cnt == ST_LAST) begin
            cnt          <= '0;
            rst_outn     <= nxt;
            all_released <= nxt_all;
            busy         <= !nxt_all;
            state        <= nxt_all ? RUN : RELEASE;
          end else cnt <= cnt + 1'b1;
        RELEASE:
          if (cnt == GAP_LAST) begin
            cnt          <= '0;
            rst_outn     <= nxt;
            all_released <= nxt_all;
            busy         <= !nxt_all;
            state        <= nxt_all ? RUN : RELEASE;
          end else cnt <= cnt + 1'b1;
        RUN: cnt <= '0;
        default: state <= HOLD;
      endcase
    end
endmodule
